// File: rtl/ariane_reset_seq_if.sv
// rtl/ariane_reset_seq_if.sv - wake/soft-reset request inputs and core reset status outputs of the reset sequencer
interface ariane_reset_seq_if;
  logic       wake_irq_i;
  logic       soft_rst_req_i;
  logic       core_rst_no;
  logic [1:0] state_o;
  logic [7:0] soft_rst_cnt_o;

  // Requester side: raises wake/soft-reset requests and observes the sequencer
  modport master (
    output wake_irq_i,
    output soft_rst_req_i,
    input  core_rst_no,
    input  state_o,
    input  soft_rst_cnt_o
  );

  // Sequencer side
  modport slave (
    input  wake_irq_i,
    input  soft_rst_req_i,
    output core_rst_no,
    output state_o,
    output soft_rst_cnt_o
  );
endinterface

// File: rtl/ariane_reset_seq.sv
// rtl/ariane_reset_seq.sv - core reset sequencer: SRAM-init wait, optional wake gate, soft resets
module ariane_reset_seq #(
  parameter int unsigned InitCycles    = 128,
  parameter int unsigned SoftRstCycles = 16,
  parameter bit          WakeOnIrq     = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ariane_reset_seq_if.slave  bus
);

  // State encoding is visible on state_o, so it is fixed rather than left to the tool
  localparam logic [1:0] ST_INIT      = 2'd0;
  localparam logic [1:0] ST_WAIT_WAKE = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_SOFT_RST  = 2'd3;

  // One counter is shared by INIT and SOFT_RST, so it is sized for the longer of the two
  localparam int unsigned CntMax = (InitCycles > SoftRstCycles) ? InitCycles : SoftRstCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] InitLast    = CntW'(InitCycles - 1);
  localparam logic [CntW-1:0] SoftRstLast = CntW'(SoftRstCycles - 1);

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [CntW-1:0] cnt_q;
  logic            wake_pending_q;
  logic [7:0]      soft_cnt_q;
  logic            init_done;
  logic            soft_done;
  logic            wake_seen;
  logic            soft_take;

  assign init_done = (state_q == ST_INIT) && (cnt_q == InitLast);
  assign soft_done = (state_q == ST_SOFT_RST) && (cnt_q == SoftRstLast);

  // A wake strobe landing on the INIT exit edge counts as already pending
  assign wake_seen = wake_pending_q || bus.wake_irq_i;

  // Soft-reset requests only act from RUN; a held request retriggers once per RUN entry
  assign soft_take = (state_q == ST_RUN) && bus.soft_rst_req_i;

  // Next-state selection; soft reset has priority over anything else in RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init_done) begin
          if (!WakeOnIrq || wake_seen) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_WAKE;
          end
        end
      end
      ST_WAIT_WAKE: begin
        if (bus.wake_irq_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (soft_take) begin
          state_d = ST_SOFT_RST;
        end
      end
      ST_SOFT_RST: begin
        if (soft_done) begin
          state_d = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Cycle counter: cleared on every state change, counts only in the timed states
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == ST_INIT) || (state_q == ST_SOFT_RST)) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Remember a wake strobe seen during INIT until INIT is left
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wake_pending_q <= 1'b0;
    end else if (state_q != ST_INIT || init_done) begin
      wake_pending_q <= 1'b0;
    end else if (bus.wake_irq_i) begin
      wake_pending_q <= 1'b1;
    end
  end

  // Core reset comes straight from a flop loaded with the next state's RUN-ness,
  // so it equals (state_q == RUN) without any combinational path to the pin
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.core_rst_no <= 1'b0;
    end else begin
      bus.core_rst_no <= (state_d == ST_RUN);
    end
  end

  // Saturating count of soft resets taken
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      soft_cnt_q <= 8'd0;
    end else if (soft_take && (soft_cnt_q != 8'hFF)) begin
      soft_cnt_q <= soft_cnt_q + 8'd1;
    end
  end

  assign bus.state_o        = state_q;
  assign bus.soft_rst_cnt_o = soft_cnt_q;

endmodule

// File: tb/tb_ariane_reset_seq.sv
// tb/tb_ariane_reset_seq.sv - directed self-checking bench for ariane_reset_seq
module tb_ariane_reset_seq;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ariane_reset_seq_if bus0 ();
  ariane_reset_seq_if bus1 ();

  ariane_reset_seq dut0 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus0.slave)
  );

  ariane_reset_seq #(.WakeOnIrq(1'b1)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release 1 time unit after an edge: next edge is edge 1
  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.wake_irq_i = 1'b0; bus0.soft_rst_req_i = 1'b0;
    bus1.wake_irq_i = 1'b0; bus1.soft_rst_req_i = 1'b0;
    #2;
    total++; if (bus0.state_o !== 2'd0) begin bad++; $display("FAIL reset_state0 got=%0d exp=0", bus0.state_o); end
    total++; if (bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL reset_core0 got=%0b exp=0", bus0.core_rst_no); end
    total++; if (bus0.soft_rst_cnt_o !== 8'd0) begin bad++; $display("FAIL reset_cnt0 got=%0d exp=0", bus0.soft_rst_cnt_o); end
    total++; if (bus1.state_o !== 2'd0) begin bad++; $display("FAIL reset_state1 got=%0d exp=0", bus1.state_o); end
    total++; if (bus1.core_rst_no !== 1'b0) begin bad++; $display("FAIL reset_core1 got=%0b exp=0", bus1.core_rst_no); end
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_init_release();
    for (int e = 1; e <= 127; e++) begin
      tick(1);
      total++;
      if (bus0.state_o !== 2'd0 || bus0.core_rst_no !== 1'b0 || bus1.state_o !== 2'd0 || bus1.core_rst_no !== 1'b0) begin
        bad++;
        $display("FAIL init_hold edge=%0d got st0=%0d rst0=%0b st1=%0d rst1=%0b exp 0/0/0/0", e, bus0.state_o, bus0.core_rst_no, bus1.state_o, bus1.core_rst_no);
      end
    end
    tick(1);
    total++; if (bus0.state_o !== 2'd2) begin bad++; $display("FAIL init_exit_state got=%0d exp=2", bus0.state_o); end
    total++; if (bus0.core_rst_no !== 1'b1) begin bad++; $display("FAIL init_exit_core got=%0b exp=1", bus0.core_rst_no); end
    total++; if (bus1.state_o !== 2'd1) begin bad++; $display("FAIL wait_wake_entry got=%0d exp=1", bus1.state_o); end
    total++; if (bus1.core_rst_no !== 1'b0) begin bad++; $display("FAIL wait_wake_core got=%0b exp=0", bus1.core_rst_no); end
    tick(171);
    total++; if (bus1.state_o !== 2'd1) begin bad++; $display("FAIL wait_wake_hold got=%0d exp=1", bus1.state_o); end
    bus1.wake_irq_i = 1'b1;
    bus0.wake_irq_i = 1'b1;
    tick(1);
    bus1.wake_irq_i = 1'b0;
    bus0.wake_irq_i = 1'b0;
    total++; if (bus1.state_o !== 2'd2) begin bad++; $display("FAIL wake_release_state got=%0d exp=2", bus1.state_o); end
    total++; if (bus1.core_rst_no !== 1'b1) begin bad++; $display("FAIL wake_release_core got=%0b exp=1", bus1.core_rst_no); end
    total++; if (bus0.state_o !== 2'd2) begin bad++; $display("FAIL wake_in_run got=%0d exp=2", bus0.state_o); end
  endtask

  task automatic test_wake_early();
    do_reset();
    tick(49);
    bus1.wake_irq_i = 1'b1;
    tick(1);
    bus1.wake_irq_i = 1'b0;
    for (int e = 51; e <= 127; e++) begin
      tick(1);
      total++;
      if (bus1.state_o !== 2'd0) begin bad++; $display("FAIL early_wake_init edge=%0d got=%0d exp=0", e, bus1.state_o); end
    end
    tick(1);
    total++; if (bus1.state_o !== 2'd2) begin bad++; $display("FAIL early_wake_exit got=%0d exp=2", bus1.state_o); end
    total++; if (bus1.core_rst_no !== 1'b1) begin bad++; $display("FAIL early_wake_core got=%0b exp=1", bus1.core_rst_no); end
  endtask

  task automatic test_wake_same_edge();
    do_reset();
    tick(127);
    bus1.wake_irq_i = 1'b1;
    tick(1);
    bus1.wake_irq_i = 1'b0;
    total++; if (bus1.state_o !== 2'd2) begin bad++; $display("FAIL same_edge_wake got=%0d exp=2", bus1.state_o); end
    total++; if (bus1.core_rst_no !== 1'b1) begin bad++; $display("FAIL same_edge_core got=%0b exp=1", bus1.core_rst_no); end
  endtask

  task automatic test_soft_rst();
    bus0.soft_rst_req_i = 1'b1;
    tick(1);
    bus0.soft_rst_req_i = 1'b0;
    total++; if (bus0.state_o !== 2'd3) begin bad++; $display("FAIL soft_enter got=%0d exp=3", bus0.state_o); end
    total++; if (bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL soft_core_low got=%0b exp=0", bus0.core_rst_no); end
    total++; if (bus0.soft_rst_cnt_o !== 8'd1) begin bad++; $display("FAIL soft_cnt got=%0d exp=1", bus0.soft_rst_cnt_o); end
    tick(15);
    total++; if (bus0.state_o !== 2'd3) begin bad++; $display("FAIL soft_hold got=%0d exp=3", bus0.state_o); end
    tick(1);
    total++; if (bus0.state_o !== 2'd0) begin bad++; $display("FAIL soft_to_init got=%0d exp=0", bus0.state_o); end
    tick(127);
    total++; if (bus0.state_o !== 2'd0 || bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL soft_reinit got st=%0d rst=%0b exp 0/0", bus0.state_o, bus0.core_rst_no); end
    tick(1);
    total++; if (bus0.state_o !== 2'd2 || bus0.core_rst_no !== 1'b1) begin bad++; $display("FAIL soft_rerun got st=%0d rst=%0b exp 2/1", bus0.state_o, bus0.core_rst_no); end
    total++; if (bus0.soft_rst_cnt_o !== 8'd1) begin bad++; $display("FAIL soft_cnt_keep got=%0d exp=1", bus0.soft_rst_cnt_o); end
    // Soft reset beats a simultaneous wake in RUN; requests in SOFT_RST are ignored
    bus1.soft_rst_req_i = 1'b1;
    bus1.wake_irq_i = 1'b1;
    tick(1);
    bus1.wake_irq_i = 1'b0;
    total++; if (bus1.state_o !== 2'd3) begin bad++; $display("FAIL soft_wins got=%0d exp=3", bus1.state_o); end
    tick(1);
    bus1.soft_rst_req_i = 1'b0;
    total++; if (bus1.soft_rst_cnt_o !== 8'd1) begin bad++; $display("FAIL soft_ignored got=%0d exp=1", bus1.soft_rst_cnt_o); end
  endtask

  task automatic test_async_reset();
    bus0.soft_rst_req_i = 1'b1;
    tick(1);
    bus0.soft_rst_req_i = 1'b0;
    tick(4);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus0.state_o !== 2'd0) begin bad++; $display("FAIL async_soft_state got=%0d exp=0", bus0.state_o); end
    total++; if (bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL async_soft_core got=%0b exp=0", bus0.core_rst_no); end
    total++; if (bus0.soft_rst_cnt_o !== 8'd0) begin bad++; $display("FAIL async_soft_cnt got=%0d exp=0", bus0.soft_rst_cnt_o); end
    total++; if (bus1.state_o !== 2'd0 || bus1.soft_rst_cnt_o !== 8'd0) begin bad++; $display("FAIL async_soft_dut1 got st=%0d cnt=%0d exp 0/0", bus1.state_o, bus1.soft_rst_cnt_o); end
    tick(1);
    rst_n = 1'b1;
    tick(60);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus0.state_o !== 2'd0 || bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL async_init got st=%0d rst=%0b exp 0/0", bus0.state_o, bus0.core_rst_no); end
    tick(1);
    rst_n = 1'b1;
    tick(127);
    total++; if (bus0.state_o !== 2'd0 || bus0.core_rst_no !== 1'b0) begin bad++; $display("FAIL restart_hold got st=%0d rst=%0b exp 0/0", bus0.state_o, bus0.core_rst_no); end
    tick(1);
    total++; if (bus0.state_o !== 2'd2 || bus0.core_rst_no !== 1'b1) begin bad++; $display("FAIL restart_exit got st=%0d rst=%0b exp 2/1", bus0.state_o, bus0.core_rst_no); end
  endtask

  task automatic test_back_to_back();
    int budget;
    int exp_cnt;
    do_reset();
    bus0.soft_rst_req_i = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      budget = 0;
      while (bus0.state_o !== 2'd2 && budget < 300) begin
        tick(1);
        budget++;
      end
      total++;
      if (budget >= 300) begin
        bad++;
        $display("FAIL b2b_timeout iter=%0d got st=%0d exp=2", k, bus0.state_o);
        break;
      end
      tick(1);
      exp_cnt = (k > 255) ? 255 : k;
      total++;
      if (bus0.state_o !== 2'd3 || bus0.soft_rst_cnt_o !== 8'(exp_cnt)) begin
        bad++;
        $display("FAIL b2b iter=%0d got st=%0d cnt=%0d exp st=3 cnt=%0d", k, bus0.state_o, bus0.soft_rst_cnt_o, exp_cnt);
      end
    end
    bus0.soft_rst_req_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_init_release();
    test_wake_early();
    test_wake_same_edge();
    test_soft_rst();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ariane_reset_seq.md
ARIANE_RESET_SEQ -- requirements
Module: ariane_reset_seq

Sits directly upstream of the core wrapper. Drives the wrapper's core reset input. Sequences the SRAM-init wait, an optional wake-interrupt gate and software-requested core resets.

Interface
REQ-001 Parameter InitCycles, default 128: number of cycles core reset is held after each INIT entry; legal range 2..65535.
REQ-002 Parameter SoftRstCycles, default 16: number of cycles spent in SOFT_RST; legal range 1..65535.
REQ-003 Parameter WakeOnIrq, default 0: when 1, release from reset also requires a wake interrupt.
REQ-004 clk_i  input  1  single clock; all flops on its rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 wake_irq_i  input  1  single-cycle wake-up interrupt strobe (e.g. L15 interrupt return), synchronous to clk_i.
REQ-007 soft_rst_req_i  input  1  level or pulse request to reset the core, synchronous to clk_i.
REQ-008 core_rst_no  output  1  active-low core reset, connected to the wrapper reset input; driven directly from a flop.
REQ-009 state_o  output  2  current state encoding: INIT=0, WAIT_WAKE=1, RUN=2, SOFT_RST=3.
REQ-010 soft_rst_cnt_o  output  8  saturating count of soft resets taken since rst_ni.

Function
REQ-011 The state machine SHALL have exactly four states: INIT, WAIT_WAKE, RUN, SOFT_RST.
REQ-012 core_rst_no SHALL be 1 if and only if the registered state is RUN.
REQ-013 The cycle counter SHALL be wide enough for max(InitCycles, SoftRstCycles) and SHALL clear on every state change.
REQ-014 INIT SHALL increment the counter every cycle.
REQ-015 INIT exit SHALL occur on the edge where the counter equals InitCycles-1.
- Exit goes to RUN if WakeOnIrq=0.
- Exit goes to RUN if wake_pending=1.
- Exit goes to WAIT_WAKE otherwise.
REQ-016 wake_irq_i asserted in INIT SHALL set wake_pending. wake_pending SHALL clear on INIT exit.
REQ-017 WAIT_WAKE SHALL move to RUN on the edge where wake_irq_i=1, and SHALL otherwise hold indefinitely.
REQ-018 wake_irq_i SHALL be ignored in RUN and SOFT_RST.
REQ-019 RUN with soft_rst_req_i=1 SHALL move to SOFT_RST on that edge, so core_rst_no falls one edge after the request is sampled.
- soft_rst_cnt_o SHALL increment by 1 on that edge, saturating at 255.
REQ-020 SOFT_RST SHALL increment the counter every cycle and SHALL move to INIT on the edge where the counter equals SoftRstCycles-1.
REQ-021 soft_rst_req_i SHALL be ignored outside RUN.
- A request held high across SOFT_RST and INIT SHALL retrigger only after RUN is re-entered.
REQ-022 If soft_rst_req_i and wake_irq_i are both high in RUN, the soft reset SHALL win.
REQ-023 If wake_irq_i arrives on the same edge as the INIT exit, it SHALL count as pending, and the exit SHALL go to RUN.

Reset
REQ-024 rst_ni low SHALL asynchronously force all of the following, from any state, including mid-INIT or mid-SOFT_RST:
- state INIT
- counter 0
- wake_pending 0
- core_rst_no 0
- state_o 0
- soft_rst_cnt_o 0
REQ-025 After rst_ni deasserts, the first increment SHALL occur on the first rising edge.
- With WakeOnIrq=0, core_rst_no SHALL rise on the InitCycles-th rising edge.
REQ-026 No output SHALL glitch high during reset.

Verification
REQ-027 Defaults, rst_ni released before edge 1, no other stimulus -> state_o=0 and core_rst_no=0 through edge 127; state_o=2 and core_rst_no=1 at edge 128.
REQ-028 WakeOnIrq=1, no wake -> state_o=1 from edge 128 onward; wake_irq_i pulsed at edge 300 -> state_o=2 and core_rst_no=1 after edge 300.
REQ-029 WakeOnIrq=1, wake_irq_i pulsed at edge 50 -> state_o=2 at edge 128; WAIT_WAKE is never entered.
REQ-030 In RUN, soft_rst_req_i pulsed at edge N -> state_o=3 and core_rst_no=0 after edge N; state_o=0 after edge N+16; core_rst_no=1 after edge N+144; soft_rst_cnt_o=1.
REQ-031 rst_ni pulsed low mid-SOFT_RST and mid-INIT -> immediate state_o=0, core_rst_no=0, soft_rst_cnt_o=0; full 128-cycle INIT restarts.
REQ-032 300 soft resets back to back -> soft_rst_cnt_o saturates at 255; soft_rst_req_i held high continuously -> exactly one soft reset per RUN entry.
